// File: rtl/usb4_lvl_pkg.sv
// Package: usb4_lvl_pkg
// Shared definitions for the receive-side level restorer. Provides the
// per-channel FSM state type and the channel index map. Channel bits are
// ordered {t_valid, trans_error, s_write, s_read} in every 4-bit vector.
package usb4_lvl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } lvl_state_t;

  localparam int NUM_CH   = 4;
  localparam int CH_READ  = 0;
  localparam int CH_WRITE = 1;
  localparam int CH_ERR   = 2;
  localparam int CH_VALID = 3;

endpackage

// File: rtl/lvl_hold.sv
// Module: lvl_hold
// Handles one channel. It turns a single-cycle event pulse into a level
// that stays held until a one-cycle ack arrives. It also keeps a sticky
// overrun bit and a saturating count of accepted pulses.
// Optional feature macro: LVL_TIMEOUT_EN. When it is defined, a held level
// clears itself after TIMEOUT cycles without ack and sets a sticky
// timeout_flag. When it is undefined, timeout_flag is tied to 0.
// Ports:
//   clk          in   single clock
//   reset_n      in   synchronous, active-low reset
//   pulse        in   event pulse
//   ack          in   consumer acknowledge pulse
//   level        out  held level (registered, one cycle after the pulse)
//   overrun      out  sticky: a pulse arrived while the level was already held
//   evt_cnt      out  pulses seen since reset, saturating
//   timeout_flag out  sticky auto-clear indicator
module lvl_hold
  import usb4_lvl_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pulse,
  input  logic             ack,
  output logic             level,
  output logic             overrun,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             timeout_flag
);

  // The expiry value must fit in the counter, and at least one held cycle
  // is needed before expiry.
  if (TIMEOUT < 1 || TIMEOUT > (1 << TIMEOUT_W)) begin : g_bad_timeout
    $error("lvl_hold: TIMEOUT does not fit in TIMEOUT_W bits");
  end

  lvl_state_t state_q, state_d;
  logic       overrun_q, overrun_d;
  logic [CNT_W-1:0] cnt_q;

`ifdef LVL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;
  logic                 tflag_q, tflag_d;
  logic                 expire;

  assign expire = (tcnt_q == TIMEOUT_W'(TIMEOUT - 1));
`endif

  // A pulse in HELD always wins over ack, so a consumer acking an old event
  // cannot drop a freshly arrived one. An ack in IDLE is ignored.
  always_comb begin
    state_d   = state_q;
    overrun_d = overrun_q;
`ifdef LVL_TIMEOUT_EN
    tflag_d   = tflag_q;
    tcnt_d    = tcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pulse) begin
          state_d = HELD;
`ifdef LVL_TIMEOUT_EN
          tflag_d = 1'b0;
          tcnt_d  = '0;
`endif
        end
      end
      HELD: begin
        if (pulse) begin
          overrun_d = !ack;
`ifdef LVL_TIMEOUT_EN
          tflag_d   = 1'b0;
          tcnt_d    = '0;
`endif
        end else if (ack) begin
          state_d   = IDLE;
          overrun_d = 1'b0;
`ifdef LVL_TIMEOUT_EN
          tflag_d   = 1'b0;
        end else if (expire) begin
          state_d = IDLE;
          tflag_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      overrun_q <= overrun_d;
    end
  end

  // Every pulse counts, including the ones that raise overrun.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (pulse && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef LVL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tcnt_q  <= '0;
      tflag_q <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      tflag_q <= tflag_d;
    end
  end

  assign timeout_flag = tflag_q;
`else
  assign timeout_flag = 1'b0;
`endif

  assign level   = (state_q == HELD);
  assign overrun = overrun_q;
  assign evt_cnt = cnt_q;

endmodule

// File: rtl/level_restorer.sv
// Module: level_restorer
// This module sits on the receive side. It turns single-cycle event pulses
// back into held level flags for slower consumers that sample levels. Each
// of the four channels is an independent lvl_hold instance.
// Optional feature macro: LVL_TIMEOUT_EN (hold timeout with auto-clear).
// Ports:
//   clk, reset_n         clock and synchronous active-low reset
//   s_read_pul .. t_valid_pul   event pulses in
//   ack[3:0]             per-channel ack {t_valid,trans_error,s_write,s_read}
//   s_read .. t_valid    held levels out
//   overrun[3:0]         sticky per-channel overrun
//   evt_cnt[4*CNT_W-1:0] per-channel saturating pulse counters, channel i
//                        at [i*CNT_W +: CNT_W]
//   timeout_flag[3:0]    sticky per-channel auto-clear indicator
module level_restorer
  import usb4_lvl_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    s_read_pul,
  input  logic                    s_write_pul,
  input  logic                    trans_error_pul,
  input  logic                    t_valid_pul,
  input  logic [NUM_CH-1:0]       ack,
  output logic                    s_read,
  output logic                    s_write,
  output logic                    trans_error,
  output logic                    t_valid,
  output logic [NUM_CH-1:0]       overrun,
  output logic [NUM_CH*CNT_W-1:0] evt_cnt,
  output logic [NUM_CH-1:0]       timeout_flag
);

  logic [NUM_CH-1:0] pul_vec;
  logic [NUM_CH-1:0] lvl_vec;

  always_comb begin
    pul_vec           = '0;
    pul_vec[CH_READ]  = s_read_pul;
    pul_vec[CH_WRITE] = s_write_pul;
    pul_vec[CH_ERR]   = trans_error_pul;
    pul_vec[CH_VALID] = t_valid_pul;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    lvl_hold #(
      .CNT_W     (CNT_W),
      .TIMEOUT_W (TIMEOUT_W),
      .TIMEOUT   (TIMEOUT)
    ) u_hold (
      .clk          (clk),
      .reset_n      (reset_n),
      .pulse        (pul_vec[i]),
      .ack          (ack[i]),
      .level        (lvl_vec[i]),
      .overrun      (overrun[i]),
      .evt_cnt      (evt_cnt[i*CNT_W +: CNT_W]),
      .timeout_flag (timeout_flag[i])
    );
  end

  assign s_read      = lvl_vec[CH_READ];
  assign s_write     = lvl_vec[CH_WRITE];
  assign trans_error = lvl_vec[CH_ERR];
  assign t_valid     = lvl_vec[CH_VALID];

endmodule

// File: tb/tb_level_restorer.sv
// Testbench: tb_level_restorer
// Directed, table-driven checks of level_restorer with CNT_W=4, TIMEOUT=10.
// The timeout sequences compile only when LVL_TIMEOUT_EN is defined. In the
// default build, a long hold is checked to stay up with no flag.
module tb_level_restorer;

  localparam int CNT_W     = 4;
  localparam int TIMEOUT_W = 8;
  localparam int TIMEOUT   = 10;

  logic clk = 1'b0;
  logic reset_n;
  logic [3:0] pul;
  logic [3:0] ack;
  logic s_read, s_write, trans_error, t_valid;
  logic [3:0] overrun;
  logic [4*CNT_W-1:0] evt_cnt;
  logic [3:0] timeout_flag;
  logic [3:0] lvl;

  int pass_cnt  = 0;
  int total_cnt = 0;

  assign lvl = {t_valid, trans_error, s_write, s_read};

  always #5 clk = ~clk;

  level_restorer #(
    .CNT_W     (CNT_W),
    .TIMEOUT_W (TIMEOUT_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .s_read_pul      (pul[0]),
    .s_write_pul     (pul[1]),
    .trans_error_pul (pul[2]),
    .t_valid_pul     (pul[3]),
    .ack             (ack),
    .s_read          (s_read),
    .s_write         (s_write),
    .trans_error     (trans_error),
    .t_valid         (t_valid),
    .overrun         (overrun),
    .evt_cnt         (evt_cnt),
    .timeout_flag    (timeout_flag)
  );

  typedef struct {
    logic [3:0] pul;
    logic [3:0] ack;
    logic [3:0] exp_lvl;
    logic [3:0] exp_ovr;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];

  // Drives one cycle of inputs at the negedge, lets the posedge sample them,
  // and then returns 1 time unit later with the pulses dropped again.
  task automatic applyStimulus(input logic [3:0] p, input logic [3:0] a);
    @(negedge clk);
    pul = p;
    ack = a;
    @(posedge clk);
    #1;
    pul = '0;
    ack = '0;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    total_cnt++;
    if (actual === expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [3:0] cntOf(input int ch);
    return evt_cnt[ch*CNT_W +: CNT_W];
  endfunction

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    pul = '0;
    ack = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    pul = '0;
    ack = '0;

    vecs[0]  = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
    vecs[1]  = '{4'b0000, 4'b0000, 4'b0001, 4'b0000};
    vecs[2]  = '{4'b0000, 4'b0001, 4'b0000, 4'b0000};
    vecs[3]  = '{4'b0000, 4'b0001, 4'b0000, 4'b0000};
    vecs[4]  = '{4'b0010, 4'b0000, 4'b0010, 4'b0000};
    vecs[5]  = '{4'b0000, 4'b0000, 4'b0010, 4'b0000};
    vecs[6]  = '{4'b0010, 4'b0000, 4'b0010, 4'b0010};
    vecs[7]  = '{4'b1000, 4'b0000, 4'b1010, 4'b0010};
    vecs[8]  = '{4'b1000, 4'b1000, 4'b1010, 4'b0010};
    vecs[9]  = '{4'b1000, 4'b0000, 4'b1010, 4'b1010};
    vecs[10] = '{4'b1000, 4'b1000, 4'b1010, 4'b0010};
    vecs[11] = '{4'b0000, 4'b1010, 4'b0000, 4'b0000};
    vecs[12] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000};
    vecs[13] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000};
    vecs[14] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000};
    vecs[15] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
    vecs[16] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_lvl", {12'h0, lvl}, 16'h0);
    checkOutput("reset_ovr", {12'h0, overrun}, 16'h0);
    checkOutput("reset_cnt", evt_cnt, 16'h0);
    checkOutput("reset_tflag", {12'h0, timeout_flag}, 16'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven sequence.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].pul, vecs[i].ack);
      checkOutput($sformatf("vec%0d_lvl", i), {12'h0, lvl}, {12'h0, vecs[i].exp_lvl});
      checkOutput($sformatf("vec%0d_ovr", i), {12'h0, overrun}, {12'h0, vecs[i].exp_ovr});
    end
    checkOutput("table_cnt", evt_cnt, 16'h4222);
    checkOutput("table_tflag", {12'h0, timeout_flag}, 16'h0);

    // Reset during HELD drops everything.
    applyStimulus(4'b1010, 4'b0000);
    applyStimulus(4'b1010, 4'b0000);
    checkOutput("pre_reset_ovr", {12'h0, overrun}, 16'h000a);
    doReset();
    checkOutput("rst_hold_lvl", {12'h0, lvl}, 16'h0);
    checkOutput("rst_hold_ovr", {12'h0, overrun}, 16'h0);
    checkOutput("rst_hold_cnt", evt_cnt, 16'h0);

    // Basic read: ack 5 cycles after the pulse.
    applyStimulus(4'b0001, 4'b0000);
    checkOutput("basic_rise", {15'h0, s_read}, 16'h1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("basic_hold", {15'h0, s_read}, 16'h1);
    end
    applyStimulus(4'b0000, 4'b0001);
    checkOutput("basic_fall", {15'h0, s_read}, 16'h0);
    checkOutput("basic_cnt", {12'h0, cntOf(0)}, 16'h1);

    // Overrun on write: pulses 3 cycles apart with no ack.
    applyStimulus(4'b0010, 4'b0000);
    applyStimulus(4'b0000, 4'b0000);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("ovr_before", {15'h0, overrun[1]}, 16'h0);
    applyStimulus(4'b0010, 4'b0000);
    checkOutput("ovr_set", {15'h0, overrun[1]}, 16'h1);
    checkOutput("ovr_cnt", {12'h0, cntOf(1)}, 16'h2);
    applyStimulus(4'b0000, 4'b0010);
    checkOutput("ovr_clr_lvl", {15'h0, s_write}, 16'h0);
    checkOutput("ovr_clr", {15'h0, overrun[1]}, 16'h0);

    // Simultaneous pulse and ack on t_valid.
    applyStimulus(4'b1000, 4'b0000);
    applyStimulus(4'b1000, 4'b1000);
    checkOutput("simul_lvl", {15'h0, t_valid}, 16'h1);
    checkOutput("simul_ovr", {15'h0, overrun[3]}, 16'h0);
    applyStimulus(4'b0000, 4'b1000);
    checkOutput("simul_fall", {15'h0, t_valid}, 16'h0);

    // Saturation on trans_error from a clean counter.
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'b0100, 4'b0000);
      applyStimulus(4'b0000, 4'b0100);
      if (i == 13) checkOutput("sat_14", {12'h0, cntOf(2)}, 16'd14);
    end
    checkOutput("sat_final", {12'h0, cntOf(2)}, 16'd15);
    checkOutput("sat_others", {evt_cnt[15:12], 4'h0, evt_cnt[7:0]}, 16'h0);

`ifdef LVL_TIMEOUT_EN
    // The level falls TIMEOUT cycles after rising and sets the flag.
    applyStimulus(4'b0001, 4'b0000);
    for (int i = 1; i < TIMEOUT; i++) begin
      applyStimulus(4'b0000, 4'b0000);
      checkOutput($sformatf("to_hold%0d", i), {15'h0, s_read}, 16'h1);
    end
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("to_fall", {15'h0, s_read}, 16'h0);
    checkOutput("to_flag", {12'h0, timeout_flag}, 16'h0001);
    applyStimulus(4'b0001, 4'b0000);
    checkOutput("to_flag_clr", {12'h0, timeout_flag}, 16'h0);

    // Ack in the expiry cycle is a normal clear with no flag.
    for (int i = 1; i < TIMEOUT; i++) applyStimulus(4'b0000, 4'b0000);
    applyStimulus(4'b0000, 4'b0001);
    checkOutput("to_ack_lvl", {15'h0, s_read}, 16'h0);
    checkOutput("to_ack_flag", {12'h0, timeout_flag}, 16'h0);
`else
    // Without the timeout, a long hold stays up and no flag appears.
    applyStimulus(4'b0001, 4'b0000);
    for (int i = 0; i < 3 * TIMEOUT; i++) applyStimulus(4'b0000, 4'b0000);
    checkOutput("notimeout_lvl", {15'h0, s_read}, 16'h1);
    checkOutput("notimeout_flag", {12'h0, timeout_flag}, 16'h0);
    applyStimulus(4'b0000, 4'b0001);
    checkOutput("notimeout_fall", {15'h0, s_read}, 16'h0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
